// File: rtl/ysyx_22050854_mul_ctrl.sv
// Sequencing controller between the EXU and a variable-latency multiplier.
// Owns the request/response handshakes, flush handling and a one-entry result cache.
//
// state | meaning
// IDLE  | waiting for a request; req_ready high unless flushing
// ISSUE | registered request presented, waiting for multiplier mul_ready
// WAIT  | multiplier running, waiting for out_valid
// DRAIN | flushed while running; swallowing the stale out_valid
// DONE  | response held until resp_ready
module ysyx_22050854_mul_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic        req_word,
    input  logic [63:0] req_src1,
    input  logic [63:0] req_src2,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        busy,
    output logic        m_valid,
    output logic        m_flush,
    output logic        m_mulw,
    output logic [1:0]  m_signed,
    output logic [63:0] m_multiplicand,
    output logic [63:0] m_multiplier,
    input  logic        m_ready,
    input  logic        m_out_valid,
    input  logic [63:0] m_result_hi,
    input  logic [63:0] m_result_lo
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MULHSU = 2'd2;
    localparam logic [1:0] OP_MULHU  = 2'd3;

    function automatic logic [1:0] sign_of(input logic [1:0] op);
        logic [1:0] s;
        case (op)
            OP_MULHSU: s = 2'b10;
            OP_MULHU:  s = 2'b00;
            default:   s = 2'b11;
        endcase
        return s;
    endfunction

    logic [2:0]  state;
    logic [1:0]  op_q;
    logic        word_q;
    logic [63:0] src1_q;
    logic [63:0] src2_q;
    logic [4:0]  rd_q;
    logic [63:0] data_q;
    logic [4:0]  rd_out_q;

    logic        cache_valid;
    logic [63:0] cache_src1;
    logic [63:0] cache_src2;
    logic [1:0]  cache_sgn;
    logic [63:0] cache_hi;
    logic [63:0] cache_lo;

    logic        accept;
    logic        in_issue;
    logic [1:0]  req_sgn;
    logic        cache_hit;
    logic [63:0] cache_data;
    logic [63:0] cap_data;

    assign req_ready = (state == IDLE) & ~flush;
    assign accept    = req_valid & req_ready;
    assign in_issue  = (state == ISSUE);
    assign req_sgn   = sign_of(req_op);

    // The low half of a product does not depend on operand signedness, so a
    // plain MUL may reuse an entry captured under any signedness.
    assign cache_hit = cache_valid & ~req_word
                     & (req_src1 == cache_src1) & (req_src2 == cache_src2)
                     & ((req_sgn == cache_sgn) | (req_op == OP_MUL));

    assign cache_data = (req_op == OP_MUL) ? cache_lo : cache_hi;
    assign cap_data   = (op_q == OP_MUL) ? m_result_lo : m_result_hi;

    assign m_valid        = in_issue & m_ready & ~flush;
    assign m_flush        = flush;
    assign m_mulw         = in_issue & word_q;
    assign m_signed       = in_issue ? sign_of(op_q) : 2'b00;
    assign m_multiplicand = in_issue ? src1_q : 64'd0;
    assign m_multiplier   = in_issue ? src2_q : 64'd0;

    assign resp_valid = (state == DONE) & ~flush;
    assign resp_data  = data_q;
    assign resp_rd    = rd_out_q;
    assign busy       = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            op_q        <= 2'd0;
            word_q      <= 1'b0;
            src1_q      <= 64'd0;
            src2_q      <= 64'd0;
            rd_q        <= 5'd0;
            data_q      <= 64'd0;
            rd_out_q    <= 5'd0;
            cache_valid <= 1'b0;
            cache_src1  <= 64'd0;
            cache_src2  <= 64'd0;
            cache_sgn   <= 2'b00;
            cache_hi    <= 64'd0;
            cache_lo    <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= req_op;
                        word_q <= req_word;
                        src1_q <= req_src1;
                        src2_q <= req_src2;
                        rd_q   <= req_rd;
                        if (cache_hit) begin
                            data_q   <= cache_data;
                            rd_out_q <= req_rd;
                            state    <= DONE;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (flush)        state <= IDLE;
                    else if (m_ready) state <= WAIT;
                end
                WAIT: begin
                    if (flush) begin
                        // a result landing in the flush cycle is simply dropped
                        state <= m_out_valid ? IDLE : DRAIN;
                    end else if (m_out_valid) begin
                        data_q   <= cap_data;
                        rd_out_q <= rd_q;
                        state    <= DONE;
                        if (!word_q) begin
                            cache_valid <= 1'b1;
                            cache_src1  <= src1_q;
                            cache_src2  <= src2_q;
                            cache_sgn   <= sign_of(op_q);
                            cache_hi    <= m_result_hi;
                            cache_lo    <= m_result_lo;
                        end
                    end
                end
                DRAIN: begin
                    if (m_out_valid) state <= IDLE;
                end
                DONE: begin
                    if (flush || resp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
